pipe_if_id_stage: RTL and testbench

- IF/ID pipeline register, 32x32 register file and load-use interlock in one block, directly downstream of the instruction-fetch stage.
- Captures `pc`/`inst` each cycle and decodes register fields.
- Reads operands, with write-through from the write-back (WB) stage.
- Drives `IFwip`, which freezes the PC register during a load-use stall.
- Presents a valid-qualified ID bundle to the ID/EX register.

---
 rtl/pipe_if_id_stage.sv | 151 +++++++++++++++
 tb/tb_pipe_if_id_stage.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_if_id_stage
// Description : IF/ID pipeline register, 32x32 register file with
//               write-through from WB, and load-use interlock. Presents a
//               valid-qualified decoded ID bundle to the ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_if_id_stage #(
  parameter int          NREG     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc,
  input  logic [31:0] inst,
  input  logic        flush,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rd,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        IFwip,
  output logic        stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] imm_ext
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  // IF/ID pipeline state
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;

  // Architectural register file; entry 0 is never written
  logic [31:0] regs_q [NREG];
  logic [31:0] regs_d [NREG];

  logic [5:0]  w_opcode;
  logic        w_uses_rt;
  logic        w_hazard;
  logic        w_stall;

  assign w_opcode = id_inst_q[31:26];
  assign rs       = id_inst_q[25:21];
  assign rt       = id_inst_q[20:16];
  assign rd       = id_inst_q[15:11];
  assign imm_ext  = {{16{id_inst_q[15]}}, id_inst_q[15:0]};
  assign id_inst  = id_inst_q;
  assign id_pc    = id_pc_q;

  // Decode which opcodes actually read rt as a source (addi/lw use rt as a destination)
  always_comb begin
    w_uses_rt = 1'b0;
    case (w_opcode)
      C_OP_RTYPE, C_OP_BEQ, C_OP_BNE, C_OP_SW: w_uses_rt = 1'b1;
      default:                                 w_uses_rt = 1'b0;
    endcase
  end

  // Load-use interlock: a load in EX targeting a source of the ID instruction;
  // a flush kills the ID instruction so it can never cause a stall
  always_comb begin
    w_hazard = (ex_rd != 5'd0) &&
               ((ex_rd == rs) || (w_uses_rt && (ex_rd == rt)));
    w_stall  = ifid_valid_q && !flush && ex_wreg && ex_m2reg && w_hazard;
  end

  assign stall    = w_stall;
  assign IFwip    = ~w_stall;
  assign id_valid = ifid_valid_q & ~w_stall;

  // Operand reads with write-through from WB; r0 always reads zero
  always_comb begin
    rs_data = regs_q[rs];
    if (rs == 5'd0) begin
      rs_data = 32'd0;
    end else if (wb_we && (wb_rd == rs)) begin
      rs_data = wb_data;
    end

    rt_data = regs_q[rt];
    if (rt == 5'd0) begin
      rt_data = 32'd0;
    end else if (wb_we && (wb_rd == rt)) begin
      rt_data = wb_data;
    end
  end

  // Next IF/ID contents: flush beats stall, stall holds, otherwise capture IF
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    if (flush) begin
      ifid_valid_d = 1'b0;
      id_inst_d    = 32'd0;
      id_pc_d      = pc;
    end else if (!w_stall) begin
      ifid_valid_d = 1'b1;
      id_inst_d    = inst;
      id_pc_d      = pc;
    end
  end

  // Next register-file contents: WB write, ignoring writes to r0
  always_comb begin
    regs_d = regs_q;
    if (wb_we && (wb_rd != 5'd0)) begin
      regs_d[wb_rd] = wb_data;
    end
  end

  // IF/ID register with asynchronous clear to a NOP at RESET_PC
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ifid_valid_q <= 1'b0;
      id_inst_q    <= 32'd0;
      id_pc_q      <= RESET_PC;
    end else begin
      ifid_valid_q <= ifid_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
    end
  end

  // Register file storage, cleared on reset
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= 32'd0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_if_id_stage
// Description : Self-checking bench for pipe_if_id_stage: directed scenarios
//               followed by random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_if_id_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc, inst;
  logic        flush, ex_wreg, ex_m2reg;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        IFwip, stall, id_valid;
  logic [31:0] id_pc, id_inst;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_data, rt_data, imm_ext;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_inst, m_pc;
  logic [31:0] m_regs [32];

  pipe_if_id_stage #(.NREG(32), .RESET_PC(C_RESET_PC)) dut (
    .clk(clk), .clrn(clrn), .pc(pc), .inst(inst), .flush(flush),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .IFwip(IFwip), .stall(stall), .id_valid(id_valid),
    .id_pc(id_pc), .id_inst(id_inst), .rs(rs), .rt(rt), .rd(rd),
    .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_reads_rt(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    return (op == 0) || (op == 4) || (op == 5) || (op == 43);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_stall();
    bit is_load_in_ex;
    bit src_match;
    is_load_in_ex = ex_wreg && ex_m2reg && (ex_rd != 0);
    src_match = (ex_rd == m_inst[25:21]) ||
                (m_reads_rt(m_inst) && ex_rd == m_inst[20:16]);
    return m_valid && !flush && is_load_in_ex && src_match;
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_inst  = 32'd0;
    m_pc    = C_RESET_PC;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  // Advance the model across one rising edge using the inputs present at it
  task automatic m_edge();
    bit s;
    s = m_stall();
    if (wb_we && wb_rd != 0) m_regs[wb_rd] = wb_data;
    if (flush) begin
      m_valid = 1'b0; m_inst = 32'd0; m_pc = pc;
    end else if (!s) begin
      m_valid = 1'b1; m_inst = inst; m_pc = pc;
    end
  endtask

  // Compare every output against the model for the current inputs
  task automatic check_all(input string tag);
    bit s;
    #2;
    s = m_stall();
    chk({tag, ".stall"},    {31'd0, stall},    {31'd0, s});
    chk({tag, ".IFwip"},    {31'd0, IFwip},    {31'd0, !s});
    chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, m_valid && !s});
    chk({tag, ".id_pc"},    id_pc,   m_pc);
    chk({tag, ".id_inst"},  id_inst, m_inst);
    chk({tag, ".rs"},       {27'd0, rs}, {27'd0, m_inst[25:21]});
    chk({tag, ".rt"},       {27'd0, rt}, {27'd0, m_inst[20:16]});
    chk({tag, ".rd"},       {27'd0, rd}, {27'd0, m_inst[15:11]});
    chk({tag, ".rs_data"},  rs_data, m_read(m_inst[25:21]));
    chk({tag, ".rt_data"},  rt_data, m_read(m_inst[20:16]));
    chk({tag, ".imm_ext"},  imm_ext, 32'($signed(m_inst[15:0])));
  endtask

  // One cycle: check before the edge (3 ns after the previous one), then clock
  task automatic cyc(input string tag);
    check_all(tag);
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk);
    m_edge();
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops [6];
    logic [31:0] w;
    ops[0] = 6'b000000; ops[1] = 6'b000100; ops[2] = 6'b000101;
    ops[3] = 6'b101011; ops[4] = 6'b001000; ops[5] = 6'b100011;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 5)];
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    clrn = 1'b0; pc = 0; inst = 0;
    idle_inputs();
    m_reset();

    // Reset state
    #12;
    check_all("reset");
    release_reset();

    // Scenario 1: straight-line fetch; first edge after release captured pc=0
    pc = 32'd4; inst = 32'h2002_0003;
    pc = 32'd0; inst = 32'h2001_0005;
    // the release edge already captured pc=0 / inst=0; feed the sequence now
    cyc("s1a");
    chk("s1.imm_ext", imm_ext, 32'h0000_0005);
    chk("s1.id_valid", {31'd0, id_valid}, 32'd1);
    pc = 32'd4; inst = 32'h2002_0003; cyc("s1b");
    pc = 32'd8; inst = 32'h0022_1820; cyc("s1c");
    chk("s1.id_pc", id_pc, 32'd8);
    chk("s1.id_inst", id_inst, 32'h0022_1820);

    // Scenario 2: write-through to rs=3, then read from the array
    pc = 32'd12; inst = 32'h0062_0020; cyc("s2a");
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    #2;
    chk("s2.bypass", rs_data, 32'hDEAD_BEEF);
    cyc("s2b");
    wb_we = 0;
    #2;
    chk("s2.array", rs_data, 32'hDEAD_BEEF);
    cyc("s2c");

    // Scenario 3: load-use on rt of an add
    pc = 32'd16; inst = 32'h0022_1820; cyc("s3a");
    pc = 32'd20; inst = 32'h2003_0007;
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd2;
    #2;
    chk("s3.stall", {31'd0, stall}, 32'd1);
    chk("s3.IFwip", {31'd0, IFwip}, 32'd0);
    cyc("s3b");
    chk("s3.held", id_inst, 32'h0022_1820);
    ex_m2reg = 0;
    #2;
    chk("s3.release", {31'd0, stall}, 32'd0);
    cyc("s3c");
    chk("s3.advance", id_inst, 32'h2003_0007);

    // Scenario 4: no false stall on addi destination rt, nor on ex_rd=0
    idle_inputs();
    pc = 32'd24; inst = 32'h2042_0001; cyc("s4a");
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd3;  // rs=2, rt=2 -> no match
    #2; chk("s4.nostall3", {31'd0, stall}, 32'd0);
    cyc("s4b");
    pc = 32'd28; inst = 32'h0000_0000; ex_rd = 5'd2; cyc("s4c");
    ex_rd = 5'd0;
    #2; chk("s4.r0", {31'd0, stall}, 32'd0);
    cyc("s4d");

    // Scenario 5: flush together with a load-use hazard
    pc = 32'd32; inst = 32'h0022_1820; idle_inputs(); cyc("s5a");
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd1; flush = 1; pc = 32'd100;
    #2;
    chk("s5.stall", {31'd0, stall}, 32'd0);
    chk("s5.IFwip", {31'd0, IFwip}, 32'd1);
    cyc("s5b");
    chk("s5.id_valid", {31'd0, id_valid}, 32'd0);
    chk("s5.id_inst", id_inst, 32'd0);

    // Scenario 6: write to r0 is discarded; then reset in the middle of a stall
    idle_inputs();
    wb_we = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    pc = 32'd36; inst = 32'h0000_0020; cyc("s6a");
    wb_we = 0; cyc("s6b");
    chk("s6.r0", rs_data, 32'd0);
    pc = 32'd40; inst = 32'h8C21_0000; cyc("s6c");
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 5'd1;
    #2;
    chk("s6.prestall", {31'd0, stall}, 32'd1);
    clrn = 1'b0;
    #1;
    m_reset();
    chk("s6.rst.stall",    {31'd0, stall},    32'd0);
    chk("s6.rst.IFwip",    {31'd0, IFwip},    32'd1);
    chk("s6.rst.id_valid", {31'd0, id_valid}, 32'd0);
    chk("s6.rst.id_pc",    id_pc,   C_RESET_PC);
    chk("s6.rst.id_inst",  id_inst, 32'd0);
    chk("s6.rst.rs_data",  rs_data, 32'd0);
    idle_inputs();
    release_reset();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      pc       = $urandom;
      inst     = rand_inst();
      flush    = ($urandom_range(0, 9) == 0);
      ex_wreg  = ($urandom_range(0, 3) != 0);
      ex_m2reg = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 2))
        0:       ex_rd = m_inst[25:21];
        1:       ex_rd = m_inst[20:16];
        default: ex_rd = 5'($urandom_range(0, 7));
      endcase
      wb_we   = $urandom_range(0, 1) == 1;
      wb_rd   = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      cyc("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
